conv_2d_accum: RTL and testbench
================================

Name: conv_2d_accum

Overview:
Parametrised successor to the fixed 3x3/1x1 convolution compute wrapper. It computes PIX_NUM parallel lanes of a KERNEL_NUM-tap signed dot product, with run-time selection between 3x3 mode (all taps summed) and 1x1 mode (tap 0 only). Results are accumulated across a variable number of input-channel beats, delimited by last_in. A saturated result per lane is emitted with a valid strobe. It sits between the line-buffer/window generator and the requantisation/output stage of the accelerator datapath.

Parameters:
PIX_NUM, 2, number of parallel pixel lanes
KERNEL_NUM, 9, taps per lane (1x1 mode uses tap 0 only)
DATA_W, 8, signed width of each activation and weight
ACC_W, 32, internal accumulator width, two's complement, wraps on overflow
OUT_W, 16, signed output width per lane, saturated from ACC_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode_1x1  in  1  0 = sum all KERNEL_NUM products; 1 = use product of tap 0 only; sampled per beat with valid_in
w_load  in  1  capture weight_in into weight register
weight_in  in  KERNEL_NUM*DATA_W  tap k at [k*DATA_W +: DATA_W], signed
valid_in  in  1  data_in beat valid
last_in  in  1  qualifies final channel beat of a group; ignored when valid_in=0
data_in  in  PIX_NUM*KERNEL_NUM*DATA_W  lane p, tap k at [(p*KERNEL_NUM+k)*DATA_W +: DATA_W], signed
valid_out  out  1  one-cycle strobe, data_out valid
data_out  out  PIX_NUM*OUT_W  lane p at [p*OUT_W +: OUT_W], signed, saturated
busy  out  1  high while any beat is in the pipeline or a partial group is held

Behaviour:
- Reset (async assert, sync release): weights=0, all pipeline valids=0, accumulator=0, state=IDLE, valid_out=0, data_out=0, busy=0.
- Weight register: loads on w_load. A beat with valid_in in the same cycle uses the previously held weights. New weights apply from the next cycle. w_load is legal at any time, including mid-group.
- S1 (cycle t+1): register all PIX_NUM*KERNEL_NUM signed products (2*DATA_W bits each), plus valid, last and mode.
- S2 (t+2): per-lane sum, sign-extended to ACC_W. 3x3 mode sums all taps. 1x1 mode takes the tap-0 product only; other taps are ignored.
- S3 (t+3): accumulator FSM, per lane in lockstep.
  - IDLE with beat, not last: acc=sum, go to ACC.
  - IDLE with beat and last: result=sum, stay IDLE, acc cleared.
  - ACC with beat, not last: acc=acc+sum.
  - ACC with beat and last: result=acc+sum, go to IDLE, acc cleared.
  - No beat: hold state and acc.
- Output: when S3 produces a result, data_out = saturate(result) to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and valid_out=1 for exactly one cycle. data_out holds its value until the next result.
- Latency: beat with last_in at cycle t produces valid_out at t+3. Throughput: one beat per cycle, no backpressure. Arbitrary valid_in gaps within a group are allowed.
- Mode may differ per beat within a group; each beat uses its own sampled mode.
- Accumulator wraps at ACC_W bits. Saturation is applied only at the output.
- busy = S1 valid | S2 valid | (state==ACC).
- Reset mid-group discards the partial sum and in-flight beats; no valid_out is produced for that group.

Test Plan:
- PIX_NUM=2, K=9, DATA_W=8, OUT_W=16. Weights all 1, data all 2, single beat with last at t -> valid_out at t+3; both lanes =18.
- Three beats with lane0 data 1, 2, 3 (all taps), weights 1, idle gaps of 0, 2 and 1 cycles -> single valid_out 3 cycles after the last beat, lane0=54. No strobe on earlier beats.
- mode_1x1=1: weight tap0=-3, other taps 5; data tap0=7, other taps 100 -> result -21.
- Saturation: data 127 and weights 127 on all taps, single beat -> 32767. Data -128 with weights 127 -> -32768 (raw -146304).
- Reset mid-group: assert rst_n=0 after 2 non-last beats of data 1, weights 1. Then send one last-beat of data 2 -> result 18. No strobe for the discarded group; busy=0 right after reset.
- Weights 1 loaded. Then assert w_load with weights 2 in the same cycle as a last-beat of data 1 -> result 9. The next beat of data 1 -> 18.

Source files
------------

// File: rtl/conv_2d_accum.sv
// Parallel-lane signed KxK (or 1x1) dot product, accumulated over channel beats, saturated out.
// Latency: last beat at t -> valid_out at t+3; accepts one beat per cycle, no backpressure.
module conv_2d_accum #(
  parameter int PIX_NUM    = 2,
  parameter int KERNEL_NUM = 9,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 mode_1x1,
  input  logic                                 w_load,
  input  logic [KERNEL_NUM*DATA_W-1:0]         weight_in,
  input  logic                                 valid_in,
  input  logic                                 last_in,
  input  logic [PIX_NUM*KERNEL_NUM*DATA_W-1:0] data_in,
  output logic                                 valid_out,
  output logic [PIX_NUM*OUT_W-1:0]             data_out,
  output logic                                 busy
);

  localparam int PROD_W = 2*DATA_W;
  localparam int TAPS   = PIX_NUM*KERNEL_NUM;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [KERNEL_NUM*DATA_W-1:0] weight_q;

  logic [TAPS*PROD_W-1:0]       prod_d;
  logic [TAPS*PROD_W-1:0]       s1_prod;
  logic                         s1_vld;
  logic                         s1_last;
  logic                         s1_mode;

  logic [PIX_NUM*ACC_W-1:0]     sum_d;
  logic [PIX_NUM*ACC_W-1:0]     s2_sum;
  logic                         s2_vld;
  logic                         s2_last;

  logic [0:0]                   state;
  logic [PIX_NUM*ACC_W-1:0]     acc;
  logic [PIX_NUM*ACC_W-1:0]     tot_d;
  logic [PIX_NUM*OUT_W-1:0]     sat_d;

  // A beat in the same cycle as w_load still sees the old weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
    end else if (w_load) begin
      weight_q <= weight_in;
    end
  end

  always_comb begin
    prod_d = '0;
    for (int p = 0; p < PIX_NUM; p++) begin
      for (int k = 0; k < KERNEL_NUM; k++) begin
        prod_d[(p*KERNEL_NUM+k)*PROD_W +: PROD_W] =
          $signed(data_in[(p*KERNEL_NUM+k)*DATA_W +: DATA_W]) *
          $signed(weight_q[k*DATA_W +: DATA_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_mode <= 1'b0;
      s1_prod <= '0;
    end else begin
      s1_vld  <= valid_in;
      s1_last <= valid_in & last_in;
      if (valid_in) begin
        s1_mode <= mode_1x1;
        s1_prod <= prod_d;
      end
    end
  end

  // 1x1 mode keeps only tap 0; the other products are simply not summed.
  always_comb begin
    sum_d = '0;
    for (int p = 0; p < PIX_NUM; p++) begin
      for (int k = 0; k < KERNEL_NUM; k++) begin
        if (!s1_mode || k == 0) begin
          sum_d[p*ACC_W +: ACC_W] = sum_d[p*ACC_W +: ACC_W] +
            {{(ACC_W-PROD_W){s1_prod[(p*KERNEL_NUM+k)*PROD_W + PROD_W-1]}},
             s1_prod[(p*KERNEL_NUM+k)*PROD_W +: PROD_W]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_sum  <= '0;
    end else begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      if (s1_vld) begin
        s2_sum <= sum_d;
      end
    end
  end

  // acc is zero whenever IDLE, but the select keeps the first-beat path explicit.
  always_comb begin
    tot_d = '0;
    sat_d = '0;
    for (int p = 0; p < PIX_NUM; p++) begin
      tot_d[p*ACC_W +: ACC_W] = ((state == ST_ACC) ? acc[p*ACC_W +: ACC_W] : {ACC_W{1'b0}}) +
                                s2_sum[p*ACC_W +: ACC_W];
      if ($signed(tot_d[p*ACC_W +: ACC_W]) > SAT_MAX) begin
        sat_d[p*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
      end else if ($signed(tot_d[p*ACC_W +: ACC_W]) < SAT_MIN) begin
        sat_d[p*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
      end else begin
        sat_d[p*OUT_W +: OUT_W] = tot_d[p*ACC_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      if (s2_vld) begin
        if (s2_last) begin
          state     <= ST_IDLE;
          acc       <= '0;
          valid_out <= 1'b1;
          data_out  <= sat_d;
        end else begin
          state <= ST_ACC;
          acc   <= tot_d;
        end
      end
    end
  end

  assign busy = s1_vld | s2_vld | (state == ST_ACC);

endmodule

// File: tb/tb_conv_2d_accum.sv
// Bench for conv_2d_accum: directed cases plus random beats against an integer reference model.
module tb_conv_2d_accum;
  localparam int PIX = 2;
  localparam int K   = 9;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int OW  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mode_1x1;
  logic                  w_load;
  logic [K*DW-1:0]       weight_in;
  logic                  valid_in;
  logic                  last_in;
  logic [PIX*K*DW-1:0]   data_in;
  logic                  valid_out;
  logic [PIX*OW-1:0]     data_out;
  logic                  busy;

  conv_2d_accum #(.PIX_NUM(PIX), .KERNEL_NUM(K), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .mode_1x1(mode_1x1), .w_load(w_load), .weight_in(weight_in),
    .valid_in(valid_in), .last_in(last_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int                 due;
    logic [PIX*OW-1:0]  v;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  int   dat[PIX][K];
  int   wt_in[K];
  int   mw[K];
  int   acc_m[PIX];
  bit   grp;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Every cycle: a strobe appears exactly when the model says a result is due.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("valid_out", valid_out, 1);
        for (int p = 0; p < PIX; p++)
          check($sformatf("lane%0d", p), $signed(data_out[p*OW +: OW]),
                $signed(exp_q[0].v[p*OW +: OW]));
        void'(exp_q.pop_front());
      end else begin
        check("no_strobe", valid_out, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_inputs();
    for (int k = 0; k < K; k++) weight_in[k*DW +: DW] = DW'(wt_in[k]);
    for (int p = 0; p < PIX; p++)
      for (int k = 0; k < K; k++) data_in[(p*K+k)*DW +: DW] = DW'(dat[p][k]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b0;
      last_in  = 1'b0;
      w_load   = 1'b0;
      tick();
    end
  endtask

  task automatic load_w();
    pack_inputs();
    valid_in = 1'b0;
    w_load   = 1'b1;
    tick();
    w_load   = 1'b0;
    for (int k = 0; k < K; k++) mw[k] = wt_in[k];
  endtask

  task automatic beat(input bit last, input bit m, input bit wl);
    exp_t e;
    int   s;
    pack_inputs();
    valid_in = 1'b1;
    last_in  = last;
    mode_1x1 = m;
    w_load   = wl;
    for (int p = 0; p < PIX; p++) begin
      s = 0;
      for (int k = 0; k < K; k++)
        if (!m || k == 0) s += dat[p][k] * mw[k];
      acc_m[p] = grp ? acc_m[p] + s : s;
    end
    if (last) begin
      e.due = cyc + 3;
      for (int p = 0; p < PIX; p++) e.v[p*OW +: OW] = OW'(sat(acc_m[p]));
      exp_q.push_back(e);
      grp = 1'b0;
    end else begin
      grp = 1'b1;
    end
    if (wl)
      for (int k = 0; k < K; k++) mw[k] = wt_in[k];
    tick();
    valid_in = 1'b0;
    w_load   = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle(5);
    check(tag, busy, longint'(grp));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    valid_in = 1'b0;
    w_load   = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid_out, 0);
    check("rst_dout", data_out, 0);
    exp_q.delete();
    grp = 1'b0;
    for (int k = 0; k < K; k++) mw[k] = 0;
    for (int p = 0; p < PIX; p++) acc_m[p] = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill(input int d);
    for (int p = 0; p < PIX; p++)
      for (int k = 0; k < K; k++) dat[p][k] = d;
  endtask

  task automatic setw(input int w);
    for (int k = 0; k < K; k++) wt_in[k] = w;
  endtask

  initial begin
    mode_1x1 = 1'b0;
    last_in  = 1'b0;
    data_in  = '0;
    weight_in = '0;
    fill(0);
    setw(0);
    do_reset();
    mon_en = 1'b1;

    // single beat, all taps: 9 * 2 = 18
    setw(1); load_w();
    fill(2); beat(1, 0, 0);
    drain("busy_single");

    // three beats with gaps, 9*(1+2+3) = 54
    idle(1);
    fill(1); beat(0, 0, 0);
    fill(2); beat(0, 0, 0);
    idle(2);
    fill(3); beat(1, 0, 0);
    drain("busy_group");

    // 1x1 mode: 7 * -3 = -21
    setw(5); wt_in[0] = -3; load_w();
    fill(100); dat[0][0] = 7; dat[1][0] = 7;
    beat(1, 1, 0);
    drain("busy_1x1");

    // saturation both ways
    setw(127); load_w();
    fill(127);  beat(1, 0, 0);
    fill(-128); beat(1, 0, 0);
    drain("busy_sat");

    // reset mid-group drops the partial sum
    setw(1); load_w();
    fill(1); beat(0, 0, 0); beat(0, 0, 0);
    drain("busy_open");
    do_reset();
    setw(1); load_w();
    fill(2); beat(1, 0, 0);
    drain("busy_after_rst");

    // weight load alongside a beat uses the old weights
    setw(1); load_w();
    fill(1); setw(2); beat(1, 0, 1);
    beat(1, 0, 0);
    drain("busy_wload");

    // random beats, modes, gaps and weight reloads
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < PIX; p++)
        for (int k = 0; k < K; k++) dat[p][k] = int'($urandom_range(255)) - 128;
      if ($urandom_range(7) == 0) begin
        for (int k = 0; k < K; k++) wt_in[k] = int'($urandom_range(255)) - 128;
        if ($urandom_range(1) == 0) load_w();
        else beat(($urandom_range(2) == 0), $urandom_range(1), 1);
      end else begin
        beat(($urandom_range(3) == 0), $urandom_range(1), 0);
      end
      if ($urandom_range(3) == 0) idle(int'($urandom_range(3)));
    end
    fill(1);
    beat(1, 0, 0);
    drain("busy_rand");
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
